// File: rtl/io_bus_ctrl.sv
// IO bus master: accepts one CPU load/store at a time, selects the addressed
// device, waits for its ack under a timeout, captures registered read data and
// returns a single-cycle response.
//
// state   | meaning
// IDLE    | ready for a CPU request
// ACCESS  | device selected, waiting for its ack or the timeout
// CAPTURE | select dropped; device read data sampled on this edge
// RESP    | one-cycle response to the CPU
module io_bus_ctrl #(
   parameter int NUM_DEV = 4,
   parameter int IDX_W   = 2,
   parameter int IDX_LSB = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cpu_req,
   input  logic                   cpu_we,
   input  logic [31:0]            cpu_addr,
   input  logic [31:0]            cpu_wdata,
   output logic                   cpu_ready,
   output logic                   cpu_resp_valid,
   output logic [31:0]            cpu_rdata,
   output logic                   cpu_err,
   output logic [31:0]            io_bus_addr,
   output logic [31:0]            io_bus_dat2,
   output logic                   io_bus_we,
   output logic [NUM_DEV-1:0]     dev_sel,
   input  logic [NUM_DEV-1:0]     dev_ack,
   input  logic [NUM_DEV*32-1:0]  dev_dat4
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

   // Last ACCESS cycle count before giving up; the counter starts at 0 so the
   // select stays high for exactly TIMEOUT cycles.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t              state;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    req_idx;
   logic [7:0]          cnt;
   logic                we_q;
   logic [NUM_DEV-1:0]  req_hit;
   logic                req_in_range;
   logic                ack_sel;
   logic [31:0]         dat_sel;

   // Decode the incoming index and mux the latched device's ack and read data.
   always_comb begin
      req_idx = cpu_addr[IDX_LSB +: IDX_W];
      req_hit = '0;
      ack_sel = 1'b0;
      dat_sel = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         req_hit[i] = (req_idx == IDX_W'(i));
         if (idx == IDX_W'(i)) begin
            ack_sel = dev_ack[i];
            dat_sel = dev_dat4[32*i +: 32];
         end
      end
      req_in_range = |req_hit;
   end

   // Transaction FSM; every CPU and bus output is a register of this block.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         idx            <= '0;
         cnt            <= '0;
         we_q           <= 1'b0;
         cpu_ready      <= 1'b1;
         cpu_resp_valid <= 1'b0;
         cpu_rdata      <= '0;
         cpu_err        <= 1'b0;
         io_bus_addr    <= '0;
         io_bus_dat2    <= '0;
         io_bus_we      <= 1'b0;
         dev_sel        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  io_bus_addr <= cpu_addr;
                  io_bus_dat2 <= cpu_wdata;
                  we_q        <= cpu_we;
                  idx         <= req_idx;
                  cnt         <= '0;
                  cpu_ready   <= 1'b0;
                  if (req_in_range) begin
                     state     <= ACCESS;
                     dev_sel   <= req_hit;
                     io_bus_we <= cpu_we;
                  end else begin
                     state          <= RESP;
                     cpu_resp_valid <= 1'b1;
                     cpu_err        <= 1'b1;
                     cpu_rdata      <= '0;
                  end
               end
            end
            ACCESS: begin
               // An ack in the limit cycle takes priority over the timeout.
               if (ack_sel) begin
                  state     <= CAPTURE;
                  dev_sel   <= '0;
                  io_bus_we <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state          <= RESP;
                  dev_sel        <= '0;
                  io_bus_we      <= 1'b0;
                  cpu_resp_valid <= 1'b1;
                  cpu_err        <= 1'b1;
                  cpu_rdata      <= '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            CAPTURE: begin
               // Device data is registered one cycle after the ack edge and
               // may be cleared on this edge, so the pre-edge value is taken.
               cpu_rdata      <= we_q ? 32'd0 : dat_sel;
               cpu_err        <= 1'b0;
               cpu_resp_valid <= 1'b1;
               state          <= RESP;
            end
            RESP: begin
               cpu_resp_valid <= 1'b0;
               cpu_ready      <= 1'b1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Bench for io_bus_ctrl: device models with programmable ack delay, a directed
// vector table, randomized transactions against a latency/result model, an
// out-of-range decode instance and an asynchronous reset abort.
module tb_io_bus_ctrl;
   localparam int ND = 4;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic          cpu_req, cpu_we, cpu_ready, cpu_resp_valid, cpu_err, io_bus_we;
   logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata, io_bus_addr, io_bus_dat2;
   logic [ND-1:0] dev_sel, dev_ack, spur;
   logic [ND*32-1:0] dev_dat4;

   logic          c3_req, c3_we, c3_ready, c3_resp_valid, c3_err, c3_bus_we;
   logic [31:0]   c3_addr, c3_wdata, c3_rdata, c3_bus_addr, c3_bus_dat2;
   logic [2:0]    c3_sel;
   logic [2:0]    c3_ack;
   logic [95:0]   c3_dat4;

   io_bus_ctrl #(.NUM_DEV(ND), .IDX_W(2), .IDX_LSB(4), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
      .cpu_err(cpu_err), .io_bus_addr(io_bus_addr), .io_bus_dat2(io_bus_dat2),
      .io_bus_we(io_bus_we), .dev_sel(dev_sel), .dev_ack(dev_ack), .dev_dat4(dev_dat4)
   );

   io_bus_ctrl #(.NUM_DEV(3), .IDX_W(2), .IDX_LSB(4), .TIMEOUT(TO)) dut3 (
      .clk(clk), .reset(reset),
      .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
      .cpu_ready(c3_ready), .cpu_resp_valid(c3_resp_valid), .cpu_rdata(c3_rdata),
      .cpu_err(c3_err), .io_bus_addr(c3_bus_addr), .io_bus_dat2(c3_bus_dat2),
      .io_bus_we(c3_bus_we), .dev_sel(c3_sel), .dev_ack(c3_ack), .dev_dat4(c3_dat4)
   );

   assign c3_ack  = 3'b111;
   assign c3_dat4 = '0;

   // Device models: ack after dly[i] wait cycles, read data registered on the
   // ack edge and cleared afterwards, stores latched into an LED-style register.
   int          dly  [ND];
   logic [31:0] rval [ND];
   logic [31:0] led  [ND];
   int          wcnt [ND];

   always_comb begin
      for (int i = 0; i < ND; i++)
         dev_ack[i] = (dev_sel[i] && (wcnt[i] >= dly[i])) || spur[i];
   end

   always @(posedge clk) begin
      for (int i = 0; i < ND; i++) begin
         wcnt[i] <= dev_sel[i] ? wcnt[i] + 1 : 0;
         if (dev_sel[i] && dev_ack[i] && !io_bus_we) dev_dat4[i*32 +: 32] <= rval[i];
         else dev_dat4[i*32 +: 32] <= '0;
         if (dev_sel[i] && dev_ack[i] && io_bus_we) led[i] <= io_bus_dat2;
      end
   end

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] addr_of(input int idx);
      return 32'h4000_0008 | (32'(idx) << 4);
   endfunction

   // Reference: result and timing follow only from ack delay versus timeout.
   function automatic void model(input bit we, input int delay, input logic [31:0] rv,
                                 output int lat, output logic [31:0] rd, output logic er,
                                 output int selc, output int wec);
      if (delay >= TO) begin
         lat = TO + 1; er = 1'b1; rd = '0; selc = TO;
      end else begin
         lat = delay + 3; er = 1'b0; rd = we ? 32'd0 : rv; selc = delay + 1;
      end
      wec = we ? selc : 0;
   endfunction

   task automatic run_txn(input bit we, input int idx, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int selc, output logic [ND-1:0] selm, output int wec,
                          output logic [31:0] baddr);
      int guard;
      lat = -1; rd = '0; er = 1'b0; selc = 0; selm = '0; wec = 0; baddr = '0;
      guard = 0;
      @(negedge clk);
      while (!cpu_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!cpu_ready) chk("ready_wait", {31'd0, cpu_ready}, 32'd1);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr_of(idx); cpu_wdata = wdata;
      @(posedge clk);
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         cpu_req = 1'b0;
         if (dev_sel != '0) selc++;
         selm |= dev_sel;
         if (io_bus_we) wec++;
         if (cpu_resp_valid) begin
            lat = n; rd = cpu_rdata; er = cpu_err; baddr = io_bus_addr;
            chk("ready_low_in_resp", {31'd0, cpu_ready}, 32'd0);
            break;
         end
      end
      @(negedge clk);
      chk("ready_after_resp", {31'd0, cpu_ready}, 32'd1);
      chk("resp_one_cycle", {31'd0, cpu_resp_valid}, 32'd0);
   endtask

   typedef struct {
      bit          we;
      int          idx;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] rv;
      int          lat;
      bit          err;
      logic [31:0] rdata;
      int          selc;
      int          wec;
   } vec_t;

   vec_t vt[7];

   initial begin
      int lat, selc, wec, elat, eselc, ewec, rcnt, n3;
      logic [31:0] rd, baddr, erd;
      logic er, eer, c3seen;
      logic [ND-1:0] selm;
      bit we;
      int idx, delay;
      logic [31:0] rv, wd;

      vt[0] = '{1'b1, 1, 32'h0000_00A5, 0,   32'h0,         3,  1'b0, 32'h0,         1,  1};
      vt[1] = '{1'b0, 1, 32'h0,         0,   32'h0000_00A5, 3,  1'b0, 32'h0000_00A5, 1,  0};
      vt[2] = '{1'b0, 2, 32'h0,         5,   32'h1234_5678, 8,  1'b0, 32'h1234_5678, 6,  0};
      vt[3] = '{1'b0, 3, 32'h0,         255, 32'hCAFE_F00D, 17, 1'b1, 32'h0,         16, 0};
      vt[4] = '{1'b0, 0, 32'h0,         15,  32'hDEAD_BEEF, 18, 1'b0, 32'hDEAD_BEEF, 16, 0};
      vt[5] = '{1'b0, 0, 32'h0,         16,  32'h0000_0001, 17, 1'b1, 32'h0,         16, 0};
      vt[6] = '{1'b1, 2, 32'h0000_0055, 2,   32'h0,         5,  1'b0, 32'h0,         3,  3};

      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; spur = '0;
      c3_req = 0; c3_we = 0; c3_addr = 0; c3_wdata = 0;
      for (int i = 0; i < ND; i++) begin dly[i] = 0; rval[i] = 0; end

      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_err", {31'd0, cpu_err}, 32'd0);
      chk("rst_sel", {28'd0, dev_sel}, 32'd0);
      chk("rst_we", {31'd0, io_bus_we}, 32'd0);
      chk("rst_addr", io_bus_addr, 32'd0);
      chk("rst_dat2", io_bus_dat2, 32'd0);

      for (int v = 0; v < 7; v++) begin
         dly[vt[v].idx] = vt[v].delay;
         rval[vt[v].idx] = vt[v].rv;
         run_txn(vt[v].we, vt[v].idx, vt[v].wdata, lat, rd, er, selc, selm, wec, baddr);
         chk($sformatf("vec%0d_latency", v), lat, vt[v].lat);
         chk($sformatf("vec%0d_rdata", v), rd, vt[v].rdata);
         chk($sformatf("vec%0d_err", v), {31'd0, er}, {31'd0, vt[v].err});
         chk($sformatf("vec%0d_sel_cycles", v), selc, vt[v].selc);
         chk($sformatf("vec%0d_sel_mask", v), {28'd0, selm}, 32'd1 << vt[v].idx);
         chk($sformatf("vec%0d_we_cycles", v), wec, vt[v].wec);
         chk($sformatf("vec%0d_bus_addr", v), baddr, addr_of(vt[v].idx));
         if (vt[v].we && !vt[v].err) chk($sformatf("vec%0d_led", v), led[vt[v].idx], vt[v].wdata);
      end

      for (int r = 0; r < 40; r++) begin
         we = 1'($urandom_range(0, 1));
         idx = int'($urandom_range(0, ND - 1));
         case ($urandom_range(0, 3))
            0: delay = 0;
            1: delay = int'($urandom_range(1, 6));
            2: delay = int'($urandom_range(TO - 2, TO + 1));
            default: delay = 255;
         endcase
         rv = $urandom; wd = $urandom;
         dly[idx] = delay; rval[idx] = rv;
         spur = ND'($urandom_range(0, 15)) & ~(ND'(1) << idx);
         model(we, delay, rv, elat, erd, eer, eselc, ewec);
         run_txn(we, idx, wd, lat, rd, er, selc, selm, wec, baddr);
         spur = '0;
         chk($sformatf("rnd%0d_latency", r), lat, elat);
         chk($sformatf("rnd%0d_rdata", r), rd, erd);
         chk($sformatf("rnd%0d_err", r), {31'd0, er}, {31'd0, eer});
         chk($sformatf("rnd%0d_sel_cycles", r), selc, eselc);
         chk($sformatf("rnd%0d_we_cycles", r), wec, ewec);
         if (we && !eer) chk($sformatf("rnd%0d_led", r), led[idx], wd);
      end

      // Out-of-range index on the three-device instance, then an in-range store.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         c3_req = 1'b1; c3_we = (k == 1); c3_wdata = 32'h77;
         c3_addr = (k == 0) ? 32'h0000_0030 : 32'h0000_0010;
         @(posedge clk);
         n3 = -1; c3seen = 1'b0; er = 1'b0; rd = 32'hFFFF_FFFF;
         for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            c3_req = 1'b0;
            if (c3_sel != '0) c3seen = 1'b1;
            if (c3_resp_valid) begin n3 = n; er = c3_err; rd = c3_rdata; break; end
         end
         chk($sformatf("c3_%0d_latency", k), n3, (k == 0) ? 32'd1 : 32'd3);
         chk($sformatf("c3_%0d_err", k), {31'd0, er}, (k == 0) ? 32'd1 : 32'd0);
         chk($sformatf("c3_%0d_rdata", k), rd, 32'd0);
         chk($sformatf("c3_%0d_sel_seen", k), {31'd0, c3seen}, (k == 0) ? 32'd0 : 32'd1);
         @(negedge clk);
      end

      // Asynchronous reset during ACCESS aborts the transaction silently.
      dly[2] = 255;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr_of(2);
      @(posedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      @(negedge clk);
      chk("abort_sel_before", {28'd0, dev_sel}, 32'd4);
      #2 reset = 1'b0;
      #1;
      chk("abort_sel_async", {28'd0, dev_sel}, 32'd0);
      chk("abort_ready_in_reset", {31'd0, cpu_ready}, 32'd1);
      rcnt = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (cpu_resp_valid) rcnt++;
      end
      reset = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (cpu_resp_valid) rcnt++;
         if (dev_sel != '0) rcnt++;
      end
      chk("abort_no_resp", rcnt, 32'd0);
      chk("abort_ready_after", {31'd0, cpu_ready}, 32'd1);
      dly[1] = 0; rval[1] = 32'h0000_00A5;
      run_txn(1'b0, 1, 32'h0, lat, rd, er, selc, selm, wec, baddr);
      chk("post_rst_latency", lat, 32'd3);
      chk("post_rst_rdata", rd, 32'h0000_00A5);
      chk("post_rst_err", {31'd0, er}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/io_bus_ctrl.md
# io_bus_ctrl

IO bus master that sits directly upstream of the memory-mapped IO devices (LED, switches, timers) on the single-master IO bus. It accepts one CPU load/store at a time, decodes a device index from the address, drives the selected device's `sel`, waits for its `ack` under a timeout, captures the device's registered read data one cycle later and returns a single-cycle response to the CPU. All device-side signals follow the existing IO bus convention: devices sample `sel`/`we`/`dat2` on the clock edge and present read data on `dat4` in the following cycle.

## Interface
- `NUM_DEV`, 4: number of device slots; legal values 2..16.
- `IDX_W`, 2: width of the device index field; NUM_DEV ≤ 2^IDX_W.
- `IDX_LSB`, 4: bit position of the index field in `cpu_addr`.
- `TIMEOUT`, 16: maximum ACCESS cycles without `ack` before an error response; range 1..255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces reset immediately.
- `cpu_req` in 1: request valid.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data.
- `cpu_ready` out 1: request accepted on this edge when `cpu_req & cpu_ready`.
- `cpu_resp_valid` out 1: one-cycle response pulse.
- `cpu_rdata` out 32: load data; valid only with `cpu_resp_valid`.
- `cpu_err` out 1: error flag; valid only with `cpu_resp_valid`.
- `io_bus_addr` out 32: latched request address.
- `io_bus_dat2` out 32: latched write data.
- `io_bus_we` out 1: latched write enable, gated by ACCESS.
- `dev_sel` out NUM_DEV: one-hot device select.
- `dev_ack` in NUM_DEV: per-device acknowledge.
- `dev_dat4` in NUM_DEV*32: per-device read data, device i at bits [32i+31:32i].

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: `cpu_ready`=1. On `cpu_req`, latch `addr`, `wdata`, `we` and `idx = cpu_addr[IDX_LSB+IDX_W-1:IDX_LSB]`, then clear the timeout counter.
  - If `idx < NUM_DEV`: go to ACCESS.
  - Otherwise: go to RESP with `err`=1 and `rdata`=0; no device is selected.
- ACCESS: `dev_sel[idx]`=1, `io_bus_we`=latched we, and addr/dat2 are driven.
  - If `dev_ack[idx]`=1: go to CAPTURE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ack, go to RESP with `err`=1 and `rdata`=0.
  - `ack` from non-selected devices is ignored.
- CAPTURE: `dev_sel`=0 and `io_bus_we`=0. On the edge, `rdata <= we ? 0 : dev_dat4[idx]`, `err <= 0`, then go to RESP. Sampling happens on the same edge on which devices may clear their output registers; the pre-edge value is the one captured.
- RESP: `cpu_resp_valid`=1 with registered `cpu_rdata`/`cpu_err`; `cpu_ready`=0. Go to IDLE next cycle.
- `cpu_ready`=1 only in IDLE, so requests are never overlapped. Address and data are held stable from acceptance until the return to IDLE.

## Timing
- Reset values: state IDLE, `cpu_ready`=1, `cpu_resp_valid`=0, `cpu_rdata`=0, `cpu_err`=0, `dev_sel`=0, `io_bus_we`=0, `io_bus_addr`=0, `io_bus_dat2`=0, counter 0.
- Reset asserted mid-transaction aborts it: `dev_sel` drops asynchronously and no response is issued.
- Accept edge at T: ACCESS in T+1. With ack in T+1: CAPTURE T+2, `cpu_resp_valid` in T+3, `cpu_ready` high again in T+4. Minimum issue interval is 4 cycles.
- An ack arriving after k extra wait cycles adds k cycles.
- Timeout: `dev_sel` is high for exactly TIMEOUT cycles, then RESP the next cycle.
- Out-of-range index: RESP in T+1, no bus activity.
- An ack arriving in the same cycle the counter hits its limit wins; the result is a normal CAPTURE.
- Outputs `cpu_*`, `dev_sel` and `io_bus_*` are decoded from registered state only; there is no combinational path from `cpu_*` inputs.

## Test plan
- Store 0x000000A5 to idx 1 with an always-ack device: `dev_sel`=4'b0010 and `io_bus_we`=1 for exactly 1 cycle. `cpu_resp_valid` arrives 3 cycles after accept with `rdata`=0 and `err`=0. LED-style device output reads 0xA5.
- Load from idx 1, where the device registers 0x000000A5 onto `dat4` the cycle after sel and clears it afterwards: `cpu_rdata`=0x000000A5, `err`=0.
- Device 2 acks after 5 wait cycles with read data 0x12345678: `dev_sel[2]` is high for 6 cycles; response `rdata`=0x12345678 at accept+8.
- Device 3 never acks, TIMEOUT=16: `dev_sel[3]` is high for 16 cycles, then response with `err`=1 and `rdata`=0. The next request is accepted normally.
- NUM_DEV=3 with `cpu_addr`=0x00000030 (idx 3): no `dev_sel` activity; response at accept+1 with `err`=1.
- `reset`=0 pulsed asynchronously during ACCESS: `dev_sel` drops immediately and no `cpu_resp_valid` occurs. After `reset`=1, `cpu_ready`=1 and a following load completes with correct data.
